// File: rtl/tank_bullet.sv
// Projectile stage for the player tank: launches one bullet from the tank's
// leading edge when the fire key is pressed. The bullet moves every frame until
// it hits the opponent, hits a barrier, reaches the field edge or runs out of
// range. A fixed cooldown follows every termination.
module tank_bullet #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] BULLET_SIZE     = 10'd2,
  parameter logic [9:0] BULLET_STEP     = 10'd4,
  parameter logic [9:0] X_MIN           = 10'd1,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd1,
  parameter logic [9:0] Y_MAX           = 10'd479,
  parameter logic [7:0] MAX_FRAMES      = 8'd120,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [9:0] tank_s,
  input  logic [1:0] tank_dir,
  input  logic       barrier_hit,
  input  logic       target_hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [9:0] bullet_s,
  output logic       bullet_active,
  output logic       score_pulse
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLY      = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  logic [1:0] state;
  logic [1:0] dir;
  logic [7:0] prev_key;
  logic [7:0] range_cnt;
  logic [7:0] cool_cnt;

  logic       fire_edge;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic       spawn_ok;
  logic       at_bound;

  // Widened copies so spawn and boundary sums can never wrap.
  logic [11:0] tx, ty, ts, bsz, stp, xmin, xmax, ymin, ymax, bx, by;

  assign tx   = {2'b00, tank_x};
  assign ty   = {2'b00, tank_y};
  assign ts   = {2'b00, tank_s};
  assign bsz  = {2'b00, BULLET_SIZE};
  assign stp  = {2'b00, BULLET_STEP};
  assign xmin = {2'b00, X_MIN};
  assign xmax = {2'b00, X_MAX};
  assign ymin = {2'b00, Y_MIN};
  assign ymax = {2'b00, Y_MAX};
  assign bx   = {2'b00, bullet_x};
  assign by   = {2'b00, bullet_y};

  assign fire_edge = (keycode == FIRE_KEY) && (prev_key != FIRE_KEY);
  assign bullet_s  = BULLET_SIZE;

  // Spawn point and legality: the bullet's leading edge must lie inside the field.
  always_comb begin
    spawn_x  = tank_x;
    spawn_y  = tank_y;
    spawn_ok = 1'b0;
    case (tank_dir)
      DIR_LEFT: begin
        spawn_x  = 10'(tx - ts - bsz);
        spawn_ok = (tx >= ts + bsz + bsz + xmin);
      end
      DIR_RIGHT: begin
        spawn_x  = 10'(tx + ts + bsz);
        spawn_ok = (tx + ts + bsz + bsz <= xmax);
      end
      DIR_DOWN: begin
        spawn_y  = 10'(ty + ts + bsz);
        spawn_ok = (ty + ts + bsz + bsz <= ymax);
      end
      default: begin
        spawn_y  = 10'(ty - ts - bsz);
        spawn_ok = (ty >= ts + bsz + bsz + ymin);
      end
    endcase
  end

  // Field-edge test in the latched flight direction.
  always_comb begin
    at_bound = 1'b0;
    case (dir)
      DIR_LEFT:  at_bound = (bx <= xmin + bsz + stp);
      DIR_RIGHT: at_bound = (bx + bsz + stp >= xmax);
      DIR_DOWN:  at_bound = (by + bsz + stp >= ymax);
      default:   at_bound = (by <= ymin + bsz + stp);
    endcase
  end

  // Bullet FSM: launch, per-frame flight with prioritised termination, cooldown.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= IDLE;
      dir           <= DIR_LEFT;
      prev_key      <= FIRE_KEY;
      range_cnt     <= '0;
      cool_cnt      <= '0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      score_pulse   <= 1'b0;
    end else begin
      prev_key    <= keycode;
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_edge && spawn_ok) begin
            state         <= FLY;
            dir           <= tank_dir;
            bullet_x      <= spawn_x;
            bullet_y      <= spawn_y;
            bullet_active <= 1'b1;
            range_cnt     <= '0;
          end
        end
        FLY: begin
          if (target_hit || barrier_hit || at_bound ||
              (range_cnt == MAX_FRAMES - 8'd1)) begin
            state         <= COOLDOWN;
            bullet_active <= 1'b0;
            cool_cnt      <= '0;
            score_pulse   <= target_hit;
          end else begin
            range_cnt <= range_cnt + 8'd1;
            case (dir)
              DIR_LEFT:  bullet_x <= bullet_x - BULLET_STEP;
              DIR_RIGHT: bullet_x <= bullet_x + BULLET_STEP;
              DIR_DOWN:  bullet_y <= bullet_y + BULLET_STEP;
              default:   bullet_y <= bullet_y - BULLET_STEP;
            endcase
          end
        end
        COOLDOWN: begin
          if (cool_cnt == COOLDOWN_FRAMES - 8'd1) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
